// File: rtl/imem_program_encoder_if.sv
// imem_program_encoder_if: request, instruction-memory write and status signals of the program encoder
interface imem_program_encoder_if #(parameter int ADDR_WIDTH = 8);
  logic prog_start;
  logic req_valid;
  logic req_ready;
  logic [5:0] req_op;
  logic [5:0] req_funct;
  logic [4:0] req_rs;
  logic [4:0] req_rt;
  logic [4:0] req_rd;
  logic [4:0] req_shamt;
  logic [15:0] req_imm;
  logic [25:0] req_target;
  logic mem_we;
  logic mem_busy;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [ADDR_WIDTH:0] words_written;
  logic full;
  logic err_illegal;
  modport master (
    output prog_start, req_valid, req_op, req_funct, req_rs, req_rt, req_rd, req_shamt, req_imm, req_target, mem_busy,
    input req_ready, mem_we, mem_addr, mem_wdata, words_written, full, err_illegal
  );
  modport slave (
    input prog_start, req_valid, req_op, req_funct, req_rs, req_rt, req_rd, req_shamt, req_imm, req_target, mem_busy,
    output req_ready, mem_we, mem_addr, mem_wdata, words_written, full, err_illegal
  );
endinterface

// File: rtl/imem_program_encoder.sv
// imem_program_encoder: packs field-level requests into MIPS R/I/J words and writes them to sequential imem addresses
module imem_program_encoder #(
  parameter int ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic reset,
  imem_program_encoder_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CAP = 2 ** ADDR_WIDTH;
  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;
  state_t state_q, state_d;
  logic [FIFO_DEPTH-1:0][31:0] fifo_q, fifo_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0] cnt_q, cnt_d;
  logic slot_q, slot_d;
  logic [31:0] wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0] words_q, words_d;
  logic err_q, err_d;
  logic is_r, is_i, is_j, legal, accept, push, pop, done;
  logic [31:0] enc;
  // capacity counts words already written plus everything still queued or in the output slot
  assign bus.req_ready = state_q == LOAD && int'(cnt_q) < FIFO_DEPTH
                         && int'(words_q) + int'(cnt_q) + int'(slot_q) < CAP;
  assign bus.mem_we = slot_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.words_written = words_q;
  assign bus.full = state_q == FULL;
  assign bus.err_illegal = err_q;
  always_comb begin
    is_r = bus.req_op == 6'h00;
    is_i = bus.req_op inside {6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05};
    is_j = bus.req_op inside {6'h02, 6'h03};
    legal = is_r | is_i | is_j;
    enc = is_r ? {6'h00, bus.req_rs, bus.req_rt, bus.req_rd, bus.req_shamt, bus.req_funct}
        : is_j ? {bus.req_op, bus.req_target}
        : {bus.req_op, bus.req_rs, bus.req_rt, bus.req_imm};
    accept = bus.req_valid & bus.req_ready;
    done = slot_q & ~bus.mem_busy;
    push = accept & legal;
    pop = cnt_q != '0 && (!slot_q || done);
    fifo_d = fifo_q;
    if (push) fifo_d[wr_q] = enc;
    wr_d = push ? wr_q + 1'b1 : wr_q;
    rd_d = pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    slot_d = pop | (slot_q & ~done);
    wdata_d = pop ? fifo_q[rd_q] : wdata_q;
    addr_d = done ? addr_q + 1'b1 : addr_q;
    words_d = done ? words_q + 1'b1 : words_q;
    err_d = accept & ~legal;
    state_d = (state_q == LOAD && int'(words_d) == CAP) ? FULL : state_q;
    // a new program discards everything in flight, including a write completing this cycle
    if (bus.prog_start) begin
      wr_d = '0;
      rd_d = '0;
      cnt_d = '0;
      slot_d = 1'b0;
      addr_d = '0;
      words_d = '0;
      err_d = 1'b0;
      state_d = LOAD;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      fifo_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      slot_q <= 1'b0;
      wdata_q <= '0;
      addr_q <= '0;
      words_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fifo_q <= fifo_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      slot_q <= slot_d;
      wdata_q <= wdata_d;
      addr_q <= addr_d;
      words_q <= words_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_imem_program_encoder.sv
// tb_imem_program_encoder: randomized scoreboard bench with a field-level encoding model and directed boundary cases
module tb_imem_program_encoder;
  localparam int AW = 4;
  localparam int DEPTH = 4;
  localparam int CAP = 2 ** AW;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  logic [AW+31:0] sb[$];
  int n_acc, n_done;
  bit loading, err_exp, held, rand_busy, stim_done;
  logic [AW+31:0] h_word;
  logic [5:0] legal_ops [11] = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};
  imem_program_encoder_if #(.ADDR_WIDTH(AW)) bus ();
  imem_program_encoder #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // bit 32 flags a supported opcode; bits 31:0 are the instruction word
  function automatic logic [32:0] ref_enc(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                                          input logic [15:0] imm, input logic [25:0] tgt);
    logic [31:0] w;
    if (op == 6'h00) w = (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | (32'(sh) << 6) | 32'(fn);
    else if (op inside {6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05})
      w = (32'(op) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
    else if (op == 6'h02 || op == 6'h03) w = (32'(op) << 26) | 32'(tgt);
    else return {1'b0, 32'h0};
    return {1'b1, w};
  endfunction

  task automatic fld(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                     input logic [4:0] sh, input logic [5:0] fn, input logic [15:0] imm, input logic [25:0] tgt);
    bus.req_op = op;
    bus.req_rs = rs;
    bus.req_rt = rt;
    bus.req_rd = rd;
    bus.req_shamt = sh;
    bus.req_funct = fn;
    bus.req_imm = imm;
    bus.req_target = tgt;
  endtask

  task automatic set_req(input bit allow_illegal);
    logic [5:0] op;
    op = (allow_illegal && $urandom_range(0, 5) == 0) ? 6'($urandom_range(0, 63)) : legal_ops[$urandom_range(0, 10)];
    fld(op, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom), 16'($urandom), 26'($urandom));
  endtask

  task automatic send();
    int b;
    b = 0;
    bus.req_valid = 1'b1;
    @(negedge clk);
    while (!bus.req_ready && b < 200) begin
      b++;
      @(negedge clk);
    end
    chk("send_accept", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic start();
    bus.prog_start = 1'b1;
    @(posedge clk);
    #1;
    bus.prog_start = 1'b0;
  endtask

  task automatic wait_we();
    int b;
    b = 0;
    @(negedge clk);
    while (!bus.mem_we && b < 100) begin
      b++;
      @(negedge clk);
    end
    chk("mem_we_seen", 64'(bus.mem_we), 64'd1);
  endtask

  initial begin
    reset = 1'b1;
    bus.prog_start = 1'b1;
    bus.req_valid = 1'b1;
    bus.mem_busy = 1'b0;
    rand_busy = 1'b0;
    stim_done = 1'b0;
    fld(6'h08, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'd7, 26'd0);
    fork
      begin : monitor
        forever begin
          @(negedge clk);
          if (reset) begin
            sb.delete();
            n_acc = 0;
            n_done = 0;
            loading = 0;
            err_exp = 0;
            held = 0;
            continue;
          end
          chk("err_illegal", 64'(bus.err_illegal), 64'(err_exp));
          chk("words_written", 64'(bus.words_written), 64'(n_done));
          chk("full", 64'(bus.full), 64'(n_done == CAP));
          if (!loading || n_acc >= CAP) chk("req_ready_blocked", 64'(bus.req_ready), 64'd0);
          if (held) chk("stall_hold", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, {1'b1, h_word});
          err_exp = 0;
          held = 0;
          if (bus.prog_start) begin
            sb.delete();
            n_acc = 0;
            n_done = 0;
            loading = 1;
            continue;
          end
          if (bus.req_valid && bus.req_ready) begin
            logic [32:0] r;
            r = ref_enc(bus.req_op, bus.req_rs, bus.req_rt, bus.req_rd, bus.req_shamt, bus.req_funct,
                        bus.req_imm, bus.req_target);
            if (r[32]) begin
              sb.push_back({AW'(n_acc), r[31:0]});
              n_acc++;
            end else err_exp = 1;
          end
          if (bus.mem_we) begin
            if (bus.mem_busy) begin
              held = 1;
              h_word = {bus.mem_addr, bus.mem_wdata};
            end else begin
              if (sb.size() == 0) chk("unexpected_write", 64'(bus.mem_we), 64'd0);
              else chk("write", {bus.mem_addr, bus.mem_wdata}, sb.pop_front());
              n_done++;
              if (n_done == CAP) loading = 0;
            end
          end
        end
      end
      begin : busy_gen
        forever begin
          @(posedge clk);
          #1;
          if (rand_busy) bus.mem_busy = ($urandom_range(0, 2) == 0);
        end
      end
      begin : watchdog
        repeat (60000) @(posedge clk);
        chk("watchdog_stimulus_done", 64'(stim_done), 64'd1);
      end
      begin : stimulus
        int acc, b;
        bit a;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_outputs", {bus.req_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.words_written, bus.full,
                              bus.err_illegal}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.prog_start = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("idle_not_ready", 64'(bus.req_ready), 64'd0);
        @(posedge clk);
        #1;
        start();
        fld(6'h08, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'd5, 26'd0);
        send();
        @(negedge clk);
        chk("addi_latency_e0", 64'(bus.mem_we), 64'd0);
        @(negedge clk);
        chk("addi_write", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, {1'b1, 4'd0, 32'h2008_0005});
        @(posedge clk);
        #1;
        start();
        fld(6'h00, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20, 16'd0, 26'd0);
        send();
        fld(6'h23, 5'd29, 5'd8, 5'd0, 5'd0, 6'd0, 16'd4, 26'd0);
        send();
        wait_we();
        chk("rtype_write", {bus.mem_addr, bus.mem_wdata}, {4'd0, 32'h0109_5020});
        @(negedge clk);
        chk("lw_back_to_back", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, {1'b1, 4'd1, 32'h8FA8_0004});
        @(posedge clk);
        #1;
        start();
        fld(6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h010_0000);
        send();
        fld(6'h03, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h010_0000);
        send();
        wait_we();
        chk("j_write", {bus.mem_addr, bus.mem_wdata}, {4'd0, 32'h0810_0000});
        @(negedge clk);
        chk("jal_write", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, {1'b1, 4'd1, 32'h0C10_0000});
        @(posedge clk);
        #1;
        start();
        bus.mem_busy = 1'b1;
        acc = 0;
        set_req(0);
        bus.req_valid = 1'b1;
        repeat (8) begin
          @(negedge clk);
          a = bus.req_ready;
          @(posedge clk);
          #1;
          if (a) begin
            acc++;
            set_req(0);
          end
        end
        bus.req_valid = 1'b0;
        chk("stall_accepts", 64'(acc), 64'(DEPTH + 1));
        @(negedge clk);
        chk("stall_ready_low", 64'(bus.req_ready), 64'd0);
        @(posedge clk);
        #1;
        bus.mem_busy = 1'b0;
        send();
        repeat (10) @(posedge clk);
        #1;
        start();
        fld(6'h3F, 5'd1, 5'd2, 5'd3, 5'd0, 6'd0, 16'd9, 26'd0);
        send();
        @(negedge clk);
        chk("illegal_pulse", {bus.err_illegal, bus.words_written}, {1'b1, 5'd0});
        @(negedge clk);
        chk("illegal_pulse_end", {bus.err_illegal, bus.mem_we}, 64'd0);
        @(posedge clk);
        #1;
        fld(6'h0D, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'hBEEF, 26'd0);
        send();
        wait_we();
        chk("after_illegal_addr", {bus.mem_addr, bus.mem_wdata}, {4'd0, 32'h3464_BEEF});
        @(posedge clk);
        #1;
        start();
        rand_busy = 1'b1;
        repeat (CAP) begin
          set_req(0);
          send();
        end
        rand_busy = 1'b0;
        bus.mem_busy = 1'b0;
        b = 0;
        @(negedge clk);
        while (!bus.full && b < 200) begin
          b++;
          @(negedge clk);
        end
        chk("full_state", {bus.full, bus.req_ready, bus.mem_we, bus.mem_addr, bus.words_written},
            {1'b1, 1'b0, 1'b0, 4'd0, 5'(CAP)});
        @(posedge clk);
        #1;
        set_req(0);
        bus.req_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        start();
        @(negedge clk);
        chk("restart_from_full", {bus.full, bus.req_ready}, {1'b0, 1'b1});
        @(posedge clk);
        #1;
        bus.mem_busy = 1'b1;
        set_req(0);
        send();
        set_req(0);
        send();
        wait_we();
        @(posedge clk);
        #1;
        bus.prog_start = 1'b1;
        bus.mem_busy = 1'b0;
        @(posedge clk);
        #1;
        bus.prog_start = 1'b0;
        @(negedge clk);
        chk("flush_mid_stall", {bus.mem_we, bus.mem_addr, bus.words_written, bus.full}, 64'd0);
        @(posedge clk);
        #1;
        repeat (6) begin
          start();
          rand_busy = 1'b1;
          repeat ($urandom_range(4, CAP)) begin
            set_req(1);
            send();
          end
          repeat ($urandom_range(0, 8)) @(posedge clk);
          #1;
        end
        rand_busy = 1'b0;
        bus.mem_busy = 1'b0;
        b = 0;
        while (sb.size() != 0 && b < 200) begin
          b++;
          @(posedge clk);
        end
        repeat (2) @(posedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        stim_done = 1'b1;
      end
    join_any
    disable fork;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
